// File: rtl/alu_seq.sv
// alu_seq: issues decoded two-address ALU operations to a registered ALU and
// writes the results back into an internal 8x8 register file (or the compare
// flag). One op is in flight at a time: IDLE -> EXEC -> WB -> IDLE.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   op_valid / op_ready         decoded-op handshake
//   op_funct, op_rd, op_rs,     decoded op: function, destination (also x
//   op_imm, op_use_imm          source), y source register or immediate
//   alu_en, alu_x, alu_y,       request to the ALU, held stable between accepts
//   alu_funct
//   alu_result, alu_cmp         registered ALU outputs, valid in the WB cycle
//   cmp_flag                    last compare outcome
//   wb_valid, wb_rd, wb_data    one-cycle register write-back report
//   illegal                     one-cycle pulse after an unsupported funct
//   dbg_addr, dbg_data          combinational register-file read port
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_funct,
    input  logic [2:0] op_rd,
    input  logic [2:0] op_rs,
    input  logic [7:0] op_imm,
    input  logic       op_use_imm,
    output logic       alu_en,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [3:0] alu_funct,
    input  logic [7:0] alu_result,
    input  logic       alu_cmp,
    output logic       cmp_flag,
    output logic       wb_valid,
    output logic [2:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       illegal,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    localparam logic [3:0] FunctCmp = 4'b0110;

    logic [1:0] state_q, state_d;
    logic [7:0] regs_q [8];
    logic [7:0] alu_x_q, alu_y_q;
    logic [3:0] alu_funct_q;
    logic [2:0] rd_q;
    logic       cmp_flag_q;
    logic       illegal_q;

    logic       accept;
    logic       op_legal;
    logic [7:0] rd_val, rs_val;
    logic       in_wb;
    logic       wb_write;

    always_comb begin
        unique case (op_funct)
            4'b0101, 4'b0100, 4'b1110, 4'b0111, 4'b0001,
            4'b0011, 4'b0010, 4'b0110, 4'b1010: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // r0 is hardwired to zero on every read path.
    assign rd_val = (op_rd == 3'd0) ? 8'h00 : regs_q[op_rd];
    assign rs_val = (op_rs == 3'd0) ? 8'h00 : regs_q[op_rs];

    // Outputs are gated by reset so an op caught mid-flight has no visible
    // effect in the reset cycle itself.
    assign op_ready = (state_q == StIdle) && !reset;
    assign accept   = op_valid && op_ready;
    assign in_wb    = (state_q == StWb) && !reset;
    assign wb_write = in_wb && (alu_funct_q != FunctCmp);

    assign alu_en    = (state_q == StExec) && !reset;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_funct = alu_funct_q;
    assign cmp_flag  = cmp_flag_q;
    assign illegal   = illegal_q;
    assign wb_valid  = wb_write;
    assign wb_rd     = wb_write ? rd_q : 3'd0;
    assign wb_data   = wb_write ? alu_result : 8'h00;
    assign dbg_data  = (dbg_addr == 3'd0) ? 8'h00 : regs_q[dbg_addr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && op_legal) state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            alu_x_q     <= 8'h00;
            alu_y_q     <= 8'h00;
            alu_funct_q <= 4'b0000;
            rd_q        <= 3'd0;
            cmp_flag_q  <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && !op_legal;
            if (accept) begin
                alu_x_q     <= rd_val;
                alu_y_q     <= op_use_imm ? op_imm : rs_val;
                alu_funct_q <= op_funct;
                rd_q        <= op_rd;
            end
            if (wb_write && (rd_q != 3'd0)) begin
                regs_q[rd_q] <= alu_result;
            end
            if (in_wb && (alu_funct_q == FunctCmp)) begin
                cmp_flag_q <= alu_cmp;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_funct;
    logic [2:0] op_rd;
    logic [2:0] op_rs;
    logic [7:0] op_imm;
    logic       op_use_imm;
    logic       alu_en;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [3:0] alu_funct;
    logic [7:0] alu_result;
    logic       alu_cmp;
    logic       cmp_flag;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       illegal;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_funct   (op_funct),
        .op_rd      (op_rd),
        .op_rs      (op_rs),
        .op_imm     (op_imm),
        .op_use_imm (op_use_imm),
        .alu_en     (alu_en),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_cmp    (alu_cmp),
        .cmp_flag   (cmp_flag),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU: the peer the sequencer talks to.
    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] x,
                                         input logic [7:0] y);
        int s;
        s = int'(y[2:0]);
        case (f)
            4'b0101: return x + y;
            4'b0100: return x - y;
            4'b1110: return x << s;
            4'b0111: return x >> s;
            4'b0001: return x ^ y;
            4'b0011: return x & y;
            4'b0010: return x | y;
            4'b1010: return y[3] ? (x >> s) : (x << s);
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (alu_en) begin
            alu_result <= alu_f(alu_funct, alu_x, alu_y);
            alu_cmp    <= (alu_x == alu_y);
        end
    end

    function automatic logic is_legal(input logic [3:0] f);
        return f inside {4'b0101, 4'b0100, 4'b1110, 4'b0111, 4'b0001,
                         4'b0011, 4'b0010, 4'b0110, 4'b1010};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] funct;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic       use_imm;
        logic [7:0] x;     // expected alu_x
        logic [7:0] y;     // expected alu_y
        logic       ill;   // expected illegal pulse
        logic       wb;    // expected wb_valid
        logic [7:0] data;  // expected wb_data
        logic       flag;  // expected cmp_flag at T+3
        logic [7:0] dbg;   // expected regs[rd] at T+3
    } vec_t;

    // Called #1 after a rising edge with the DUT idle.
    task automatic issue(input vec_t v);
        op_funct   = v.funct;
        op_rd      = v.rd;
        op_rs      = v.rs;
        op_imm     = v.imm;
        op_use_imm = v.use_imm;
        op_valid   = 1'b1;
        dbg_addr   = v.rd;
        check("ready_idle", op_ready, 1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (v.ill) begin
            check("illegal_t1", illegal, 1);
            check("alu_en_ill", alu_en, 0);
            check("ready_ill_t1", op_ready, 1);
            @(posedge clk); #1;
            check("illegal_t2", illegal, 0);
            check("alu_en_ill2", alu_en, 0);
            check("flag_ill", cmp_flag, v.flag);
            check("dbg_ill", dbg_data, v.dbg);
        end else begin
            check("illegal_0", illegal, 0);
            check("alu_en_t1", alu_en, 1);
            check("alu_x", alu_x, v.x);
            check("alu_y", alu_y, v.y);
            check("alu_funct", alu_funct, v.funct);
            check("ready_t1", op_ready, 0);
            check("wb_t1", wb_valid, 0);
            @(posedge clk); #1;
            check("alu_en_t2", alu_en, 0);
            check("wb_valid", wb_valid, v.wb);
            if (v.wb) begin
                check("wb_rd", wb_rd, v.rd);
                check("wb_data", wb_data, v.data);
            end
            check("dbg_prewrite", dbg_data, v.x);
            @(posedge clk); #1;
            check("ready_t3", op_ready, 1);
            check("wb_t3", wb_valid, 0);
            check("cmp_flag", cmp_flag, v.flag);
            check("dbg_t3", dbg_data, v.dbg);
        end
    endtask

    vec_t tbl [15];
    logic [3:0] legal_list [9];
    logic [7:0] m_regs [8];
    logic       m_flag;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          funct    rd    rs    imm    ui    x      y      il wb data   fl dbg
        tbl[0]  = '{4'b0101, 3'd1, 3'd0, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C};
        tbl[1]  = '{4'b0100, 3'd1, 3'd0, 8'h3D, 1'b1, 8'h3C, 8'h3D, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF};
        tbl[2]  = '{4'b0101, 3'd2, 3'd0, 8'h81, 1'b1, 8'h00, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 8'h81};
        tbl[3]  = '{4'b1010, 3'd2, 3'd0, 8'h09, 1'b1, 8'h81, 8'h09, 1'b0, 1'b1, 8'h40, 1'b0, 8'h40};
        tbl[4]  = '{4'b1010, 3'd2, 3'd0, 8'h02, 1'b1, 8'h40, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{4'b0101, 3'd1, 3'd0, 8'h3D, 1'b1, 8'hFF, 8'h3D, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C};
        tbl[6]  = '{4'b0101, 3'd3, 3'd0, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C};
        tbl[7]  = '{4'b0110, 3'd1, 3'd2, 8'h00, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C};
        tbl[8]  = '{4'b0110, 3'd1, 3'd3, 8'h00, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[9]  = '{4'b1111, 3'd1, 3'd0, 8'hAA, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
        tbl[10] = '{4'b0101, 3'd0, 3'd0, 8'h55, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 8'h00};
        tbl[11] = '{4'b0001, 3'd3, 3'd1, 8'h00, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00};
        tbl[12] = '{4'b0010, 3'd2, 3'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5};
        tbl[13] = '{4'b0011, 3'd2, 3'd0, 8'h0F, 1'b1, 8'hA5, 8'h0F, 1'b0, 1'b1, 8'h05, 1'b1, 8'h05};
        tbl[14] = '{4'b1110, 3'd1, 3'd0, 8'h03, 1'b1, 8'h3C, 8'h03, 1'b0, 1'b1, 8'hE0, 1'b1, 8'hE0};
        legal_list = '{4'b0101, 4'b0100, 4'b1110, 4'b0111, 4'b0001,
                       4'b0011, 4'b0010, 4'b0110, 4'b1010};

        reset = 1'b1;
        op_valid = 1'b0;
        op_funct = 4'd0;
        op_rd = 3'd0;
        op_rs = 3'd0;
        op_imm = 8'h00;
        op_use_imm = 1'b0;
        dbg_addr = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", op_ready, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_y", alu_y, 0);
        check("rst_alu_funct", alu_funct, 0);
        check("rst_cmp_flag", cmp_flag, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_illegal", illegal, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", op_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i]);
        end

        // Back-to-back: op_valid held high for three ADD r4,#1.
        begin
            int acc_n;
            int acc_cyc [3];
            logic [11:0] en_seen;
            acc_n = 0;
            en_seen = '0;
            op_funct = 4'b0101;
            op_rd = 3'd4;
            op_imm = 8'h01;
            op_use_imm = 1'b1;
            op_valid = 1'b1;
            for (int c = 0; c < 12; c++) begin
                en_seen[c] = alu_en;
                if (op_valid && op_ready) begin
                    if (acc_n < 3) acc_cyc[acc_n] = c;
                    acc_n++;
                end
                @(posedge clk); #1;
                if (acc_n >= 3) op_valid = 1'b0;
            end
            check("bb_count", acc_n, 3);
            check("bb_acc0", acc_cyc[0], 0);
            check("bb_acc1", acc_cyc[1], 3);
            check("bb_acc2", acc_cyc[2], 6);
            check("bb_alu_en", en_seen, 12'b0000_1001_0010);
            dbg_addr = 3'd4;
            #1;
            check("bb_r4", dbg_data, 8'h03);
        end

        // Reset during EXEC of ADD r1,#0x10 aborts the op.
        op_funct = 4'b0101;
        op_rd = 3'd1;
        op_imm = 8'h10;
        op_use_imm = 1'b1;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("abort_exec", alu_en, 1);
        reset = 1'b1;
        #1;
        check("abort_en_gated", alu_en, 0);
        @(posedge clk); #1;
        check("abort_wb", wb_valid, 0);
        check("abort_ready_rst", op_ready, 0);
        reset = 1'b0;
        #1;
        check("abort_ready", op_ready, 1);
        @(posedge clk); #1;
        check("abort_wb2", wb_valid, 0);
        check("abort_flag", cmp_flag, 0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check("abort_regs", dbg_data, 8'h00);
        end
        @(posedge clk); #1;

        // Random ops against a register-file model.
        for (int r = 0; r < 8; r++) m_regs[r] = 8'h00;
        m_flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            vec_t v;
            v.funct   = ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                                    : legal_list[$urandom_range(0, 8)];
            v.rd      = 3'($urandom);
            v.rs      = 3'($urandom);
            v.imm     = 8'($urandom);
            v.use_imm = 1'($urandom);
            v.x       = (v.rd == 3'd0) ? 8'h00 : m_regs[v.rd];
            v.y       = v.use_imm ? v.imm : ((v.rs == 3'd0) ? 8'h00 : m_regs[v.rs]);
            v.ill     = !is_legal(v.funct);
            v.wb      = 1'b0;
            v.data    = 8'h00;
            if (!v.ill) begin
                if (v.funct == 4'b0110) begin
                    m_flag = (v.x == v.y);
                end else begin
                    v.wb   = 1'b1;
                    v.data = alu_f(v.funct, v.x, v.y);
                    if (v.rd != 3'd0) m_regs[v.rd] = v.data;
                end
            end
            v.flag = m_flag;
            v.dbg  = (v.rd == 3'd0) ? 8'h00 : m_regs[v.rd];
            issue(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

ALU operation sequencer for the 8-bit core: accepts decoded two-address ALU operations on a valid/ready handshake, reads operands from an internal 8×8 register file and drives the registered ALU (`alu_en`, `x`, `y`, `funct`). It collects `result`/`cmp` one cycle later and writes back to the register file or the compare flag. It is the issuing and consuming end of the ALU interface, sitting between instruction decode and the ALU.

## Interface

- No parameters; data width 8, 8 registers, funct width 4 are fixed.
- Reset is synchronous and active-high. There is one clock.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: decoded op present.
- `op_ready` out 1: sequencer can accept; transfer when `op_valid && op_ready` at a rising edge.
- `op_funct` in 4: ALU function code.
- `op_rd` in 3: destination register, also source of `x`.
- `op_rs` in 3: source register for `y` when `op_use_imm`=0.
- `op_imm` in 8: immediate `y` when `op_use_imm`=1.
- `op_use_imm` in 1: select immediate for `y`.
- `alu_en` out 1: ALU enable.
- `alu_x` out 8: ALU `x` operand.
- `alu_y` out 8: ALU `y` operand.
- `alu_funct` out 4: ALU function code.
- `alu_result` in 8: registered ALU result.
- `alu_cmp` in 1: registered ALU compare.
- `cmp_flag` out 1: last compare outcome.
- `wb_valid` out 1: one-cycle pulse, register written this cycle.
- `wb_rd` out 3: register being written.
- `wb_data` out 8: data being written.
- `illegal` out 1: one-cycle pulse, unsupported funct accepted and dropped.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out 8: combinational read of `regs[dbg_addr]`.

## Operation

- Legal funct codes:
  - 0101 add
  - 0100 sub
  - 1110 shl
  - 0111 shr
  - 0001 xor
  - 0011 and
  - 0010 or
  - 0110 cmp
  - 1010 sh (y[3]=1 right, else left, by y[2:0])
- Any other funct is illegal.
- On accept, latch the operands:
  - `alu_x` ← `regs[op_rd]`
  - `alu_y` ← `op_use_imm ? op_imm : regs[op_rs]`
  - `alu_funct` ← `op_funct`
- The latched values hold stable until the next accept.
- r0 reads as 0x00 always. Writes to r0 still pulse `wb_valid` with `wb_rd`=0, but r0 stays 0x00.
- FSM states IDLE, EXEC, WB:
  - IDLE: `op_ready`=1 (forced 0 while `reset` high). On accept with a legal funct, go to EXEC. On accept with an illegal funct, pulse `illegal` next cycle, stay IDLE, no `alu_en`.
  - EXEC: `alu_en`=1 for exactly this cycle; the ALU registers the result at the closing edge. Go to WB.
  - WB, non-cmp funct: `wb_valid`=1, `wb_rd`=latched rd, `wb_data`=`alu_result`. The register file is written at the closing edge; `cmp_flag` is unchanged.
  - WB, cmp funct: no write, `wb_valid`=0; `cmp_flag` ← `alu_cmp` at the closing edge.
  - WB always returns to IDLE.
- Arithmetic is done entirely in the ALU. The result is 8 bits modulo 256 and the sequencer never widens or checks it.
- `dbg_data` shows pre-write contents during WB and updated contents from the next cycle.
- Reset:
  - state IDLE
  - all regs 0x00
  - `cmp_flag`=0
  - `alu_x`/`alu_y`=0x00, `alu_funct`=0000
  - `alu_en`/`wb_valid`/`illegal`=0, `wb_rd`=0, `wb_data`=0x00
  - `op_ready`=0 during reset, 1 the first cycle after reset is low.
- Reset in EXEC or WB aborts the op: no write, no flag update. The ALU's stale output is ignored.

## Timing

- Accept at edge ending cycle T.
- T+1: EXEC, `alu_en`=1.
- T+2: WB, `wb_valid` or flag capture.
- T+3: IDLE, `op_ready`=1, new value visible on `dbg_data`.
- Throughput is one op per 3 cycles. With `op_valid` held high, accepts happen at T, T+3, T+6…
- Illegal op: `illegal` pulses in T+1 and `op_ready`=1 in T+1.
- Read-after-write needs no interlock, because the next op's operands are read at or after T+3.
- `op_*` inputs are ignored whenever `op_ready`=0.

## Test plan

- Reset, then `ADD r1, #0x3C`:
  - T+1: `alu_en`=1, x=0x00, y=0x3C, funct 0101.
  - T+2: `wb_valid`=1, `wb_rd`=1, `wb_data`=0x3C.
  - T+3: `dbg_data`(1)=0x3C, `op_ready`=1.
- Then `SUB r1, #0x3D` → `wb_data`=0xFF (wrap). Then `ADD r2, #0x81`; `SH r2, #0x09` → 0x40; `SH r2, #0x02` → 0x00 (0x40<<2 truncated).
- r1=0x3C, r3=0x3C: `CMP r1, r3` → `cmp_flag`=1 at T+3, `wb_valid` never high. `CMP r1, r2` with r2≠r1 → `cmp_flag`=0, all regs unchanged.
- Illegal funct 1111 → `illegal`=1 in T+1 only, `alu_en` never high, `op_ready`=1 in T+1, regs and `cmp_flag` unchanged. `ADD r0, #0x55` → `wb_valid` with `wb_rd`=0, and `dbg_data`(0) stays 0x00.
- `op_valid` held high for 3 ops → accepts exactly at T, T+3, T+6, with `alu_en` at T+1, T+4, T+7.
- `reset` asserted during the EXEC cycle of `ADD r1, #0x10` → no `wb_valid`, all regs 0x00, `op_ready`=1 the cycle after reset drops.
